// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types, defaults and lane helpers for the data-memory
//                responder (access sizes, FSM states, store/load lane logic).
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int DEFAULT_DEPTH   = 1024;
    localparam int DEFAULT_LATENCY = 2;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Byte-lane enables for a store of the given size at byte offset lo.
    function automatic logic [3:0] store_be(input size_e size, input logic [1:0] lo);
        case (size)
            SIZE_BYTE: return 4'b0001 << lo;
            SIZE_HALF: return lo[1] ? 4'b1100 : 4'b0011;
            default:   return 4'b1111;
        endcase
    endfunction

    // Store data replicated across lanes so the enabled lanes pick the right bits.
    function automatic logic [31:0] store_data(input size_e size, input logic [31:0] wdata);
        case (size)
            SIZE_BYTE: return {4{wdata[7:0]}};
            SIZE_HALF: return {2{wdata[15:0]}};
            default:   return wdata;
        endcase
    endfunction

    // Select the addressed byte/half of a word and sign- or zero-extend it.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input size_e size,
                                                input logic [1:0] lo, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: return {{24{b[7] & ~uns}}, b};
            SIZE_HALF: return {{16{h[15] & ~uns}}, h};
            default:   return word;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_array
//  Description : DEPTH x 32-bit word array, per-byte write enables,
//                synchronous write and combinational read. Contents are
//                never cleared by reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] r_mem [DEPTH];

    // Write only the enabled byte lanes of the addressed word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = r_mem[addr];

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Data-memory responder with request/response handshakes,
//                configurable access latency, byte/half/word stores and
//                sign/zero-extended loads, and alignment/range checking.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          ADDR_W  = $clog2(DEPTH);
    localparam logic [3:0]  c_LAT   = 4'(LATENCY);
    localparam logic [31:0] c_DEPTH = 32'(DEPTH);

    state_e      r_state, w_stateNext;
    logic [3:0]  r_cnt, w_cntNext;
    logic [31:0] r_rdata, w_rdataNext;
    logic        r_err, w_errNext;

    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    size_e       r_size;
    logic        r_unsigned;

    logic        w_idle, w_accept, w_access, w_we, w_reqErr;
    logic        w_write, w_unsigned;
    logic [31:0] w_addr, w_wdata, w_rdWord, w_loadData;
    size_e       w_size;
    logic [3:0]  w_be;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_accept   = req_valid && w_idle;

    // In IDLE the live request drives the array (zero-latency access at the
    // acceptance edge); otherwise the latched request does.
    assign w_write    = w_idle ? req_write             : r_write;
    assign w_addr     = w_idle ? req_addr              : r_addr;
    assign w_wdata    = w_idle ? req_wdata             : r_wdata;
    assign w_size     = w_idle ? size_e'(req_size)     : r_size;
    assign w_unsigned = w_idle ? req_unsigned          : r_unsigned;

    // Misalignment, reserved size or word index beyond the array.
    always_comb begin
        w_reqErr = 1'b0;
        case (w_size)
            SIZE_HALF: w_reqErr = w_addr[0];
            SIZE_WORD: w_reqErr = |w_addr[1:0];
            SIZE_RSVD: w_reqErr = 1'b1;
            default:   w_reqErr = 1'b0;
        endcase
        if ({2'b00, w_addr[31:2]} >= c_DEPTH) begin
            w_reqErr = 1'b1;
        end
    end

    assign w_access   = (w_accept && !w_reqErr && (c_LAT == 4'd0))
                      || ((r_state == ST_WAIT) && (r_cnt == 4'd1));
    // Reset on the access edge abandons the store.
    assign w_we       = w_access && w_write && !rst;
    assign w_be       = store_be(w_size, w_addr[1:0]);
    assign w_loadData = w_write ? 32'd0
                                : load_extend(w_rdWord, w_size, w_addr[1:0], w_unsigned);

    dmem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (w_we),
        .be    (w_be),
        .addr  (w_addr[ADDR_W+1:2]),
        .wdata (store_data(w_size, w_wdata)),
        .rdata (w_rdWord)
    );

    // Next-state, wait counter and response data.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_rdataNext = r_rdata;
        w_errNext   = r_err;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_rdataNext = 32'd0;
                    w_errNext   = 1'b0;
                    if (w_reqErr) begin
                        w_stateNext = ST_RESP;
                        w_errNext   = 1'b1;
                    end else if (c_LAT == 4'd0) begin
                        w_stateNext = ST_RESP;
                        w_rdataNext = w_loadData;
                    end else begin
                        w_stateNext = ST_WAIT;
                        w_cntNext   = c_LAT;
                    end
                end
            end
            ST_WAIT: begin
                w_cntNext = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_stateNext = ST_RESP;
                    w_rdataNext = w_loadData;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    w_stateNext = ST_IDLE;
                    w_rdataNext = 32'd0;
                    w_errNext   = 1'b0;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // FSM state, counter and registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_rdata <= w_rdataNext;
            r_err   <= w_errNext;
        end
    end

    // Latch every request field at the acceptance edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_write    <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_size     <= SIZE_BYTE;
            r_unsigned <= 1'b0;
        end else if (w_accept) begin
            r_write    <= req_write;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_size     <= size_e'(req_size);
            r_unsigned <= req_unsigned;
        end
    end

    assign req_ready  = w_idle;
    assign resp_valid = (r_state == ST_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Directed self-checking bench for dmem_responder
//                (DEPTH=1024, LATENCY=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_R = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int nChecks = 0;
    int nFail   = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH   (1024),
        .LATENCY (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One full transaction: issue, measure latency, optionally stall, consume.
    task automatic xact(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                        input int expLat, input logic [31:0] expData, input logic expErr,
                        input int holdCycles);
        int guard;
        int lat;
        @(negedge clk);
        req_valid    = 1'b1;
        req_write    = wr;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check($sformatf("%s.ready", tag), {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("%s.latency", tag), lat, expLat);
        check($sformatf("%s.rdata", tag), resp_rdata, expData);
        check($sformatf("%s.err", tag), {31'd0, resp_err}, {31'd0, expErr});
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s.hold%0d.valid", tag, i), {31'd0, resp_valid}, 32'd1);
            check($sformatf("%s.hold%0d.rdata", tag, i), resp_rdata, expData);
            check($sformatf("%s.hold%0d.ready", tag, i), {31'd0, req_ready}, 32'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        check($sformatf("%s.busy_ready", tag), {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check($sformatf("%s.idle_ready", tag), {31'd0, req_ready}, 32'd1);
        check($sformatf("%s.idle_valid", tag), {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst.req_ready", {31'd0, req_ready}, 32'd1);
        check("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst.resp_rdata", resp_rdata, 32'd0);
        check("rst.resp_err", {31'd0, resp_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Word store then load
        xact("st_w10", 1'b1, 32'h10, 32'hDEADBEEF, SZ_W, 1'b0, 3, 32'h0, 1'b0, 0);
        xact("ld_w10", 1'b0, 32'h10, 32'h0, SZ_W, 1'b0, 3, 32'hDEADBEEF, 1'b0, 0);

        // Byte store over a zeroed word, then extended loads
        xact("st_w10z", 1'b1, 32'h10, 32'h0, SZ_W, 1'b0, 3, 32'h0, 1'b0, 0);
        xact("st_b13", 1'b1, 32'h13, 32'hAAAAAA80, SZ_B, 1'b0, 3, 32'h0, 1'b0, 0);
        xact("ld_b13s", 1'b0, 32'h13, 32'h0, SZ_B, 1'b0, 3, 32'hFFFFFF80, 1'b0, 0);
        xact("ld_b13u", 1'b0, 32'h13, 32'h0, SZ_B, 1'b1, 3, 32'h00000080, 1'b0, 0);
        xact("ld_w10b", 1'b0, 32'h10, 32'h0, SZ_W, 1'b0, 3, 32'h80000000, 1'b0, 0);

        // Error cases: one-cycle response, zero data, no array access
        xact("ld_h11", 1'b0, 32'h11, 32'h0, SZ_H, 1'b0, 1, 32'h0, 1'b1, 0);
        xact("st_h11", 1'b1, 32'h11, 32'hFFFF, SZ_H, 1'b0, 1, 32'h0, 1'b1, 0);
        xact("ld_w10c", 1'b0, 32'h10, 32'h0, SZ_W, 1'b0, 3, 32'h80000000, 1'b0, 0);
        xact("ld_oor", 1'b0, 32'h1000, 32'h0, SZ_W, 1'b0, 1, 32'h0, 1'b1, 0);
        xact("ld_w12", 1'b0, 32'h12, 32'h0, SZ_W, 1'b0, 1, 32'h0, 1'b1, 0);
        xact("ld_rsvd", 1'b0, 32'h10, 32'h0, SZ_R, 1'b0, 1, 32'h0, 1'b1, 0);

        // Half stores/loads on upper and lower halves
        xact("st_w14", 1'b1, 32'h14, 32'h11223344, SZ_W, 1'b0, 3, 32'h0, 1'b0, 0);
        xact("st_h16", 1'b1, 32'h16, 32'h5555BEEF, SZ_H, 1'b0, 3, 32'h0, 1'b0, 0);
        xact("ld_h16s", 1'b0, 32'h16, 32'h0, SZ_H, 1'b0, 3, 32'hFFFFBEEF, 1'b0, 0);
        xact("ld_h14u", 1'b0, 32'h14, 32'h0, SZ_H, 1'b1, 3, 32'h00003344, 1'b0, 0);
        xact("ld_b15s", 1'b0, 32'h15, 32'h0, SZ_B, 1'b0, 3, 32'h00000033, 1'b0, 0);

        // Last in-range word
        xact("st_wtop", 1'b1, 32'hFFC, 32'hCAFEF00D, SZ_W, 1'b0, 3, 32'h0, 1'b0, 0);
        xact("ld_wtop", 1'b0, 32'hFFC, 32'h0, SZ_W, 1'b0, 3, 32'hCAFEF00D, 1'b0, 0);

        // Response back-pressure for 5 cycles
        xact("ld_hold", 1'b0, 32'h14, 32'h0, SZ_W, 1'b0, 3, 32'hBEEF3344, 1'b0, 5);

        // Reset on the access edge of a pending store
        xact("st_w20", 1'b1, 32'h20, 32'hA5A5A5A5, SZ_W, 1'b0, 3, 32'h0, 1'b0, 0);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h12345678;
        req_size  = SZ_W;
        check("rstwait.ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstwait.resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rstwait.resp_rdata", resp_rdata, 32'd0);
        check("rstwait.resp_err", {31'd0, resp_err}, 32'd0);
        check("rstwait.req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        xact("ld_w20", 1'b0, 32'h20, 32'h0, SZ_W, 1'b0, 3, 32'hA5A5A5A5, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
`default_nettype wire
